// File: rtl/common_crc_framer.sv
// Streaming CRC framer: passes payload beats through a one-entry output register
// while accumulating a running CRC, then appends the final CRC as CRC_W/DATA_W
// extra beats, most significant slice first.
module common_crc_framer #(
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLYNOM    = 16'h1021,
    parameter bit               FEED_LSB   = 1'b0,
    parameter logic [CRC_W-1:0] CRC_INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0] CRC_XOROUT = 16'h0000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_crc_o
);

    localparam int unsigned NBEATS = CRC_W / DATA_W;
    localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {StData, StCrc} state_e;

    // Normal-form LFSR advanced by DATA_W input bits.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic [DATA_W-1:0] din);
        logic [CRC_W-1:0] c;
        logic             din_bit;
        logic             fb;
        c = crc;
        for (int i = 0; i < int'(DATA_W); i++) begin
            din_bit = FEED_LSB ? din[i] : din[DATA_W-1-i];
            fb      = c[CRC_W-1] ^ din_bit;
            c       = {c[CRC_W-2:0], 1'b0};
            c[0]    = fb;
            for (int j = 1; j < int'(CRC_W); j++) begin
                if (POLYNOM[j]) c[j] = c[j] ^ fb;
            end
        end
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   crc_fin_q, crc_fin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               out_crc_q, out_crc_d;

    logic               slot_free;
    logic               accept;
    logic               last_slice;
    logic [CRC_W-1:0]   crc_next;
    logic [DATA_W-1:0]  crc_slice;

    // The output register can take a new beat when empty or being drained this cycle.
    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == StData) && slot_free && !clear_i;
    assign accept     = in_valid_i && in_ready_o;
    assign last_slice = (idx_q == IDX_W'(NBEATS - 1));

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_crc_o   = out_crc_q;

    // CRC advanced by the beat currently presented on the input.
    always_comb begin
        crc_next = crc_step(crc_q, in_data_i);
    end

    // Select the final-CRC slice addressed by the beat index, MSB slice first.
    always_comb begin
        crc_slice = '0;
        for (int k = 0; k < int'(NBEATS); k++) begin
            if (idx_q == IDX_W'(k)) crc_slice = crc_fin_q[CRC_W-1-k*DATA_W -: DATA_W];
        end
    end

    // Frame engine next-state and output-register loading.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        crc_fin_d   = crc_fin_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_crc_d   = out_crc_q;

        if (clear_i) begin
            // Abort wins over everything; held data/flags are don't-care once invalid.
            state_d     = StData;
            crc_d       = CRC_INIT;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StData: begin
                    if (accept) begin
                        out_data_d  = in_data_i;
                        out_crc_d   = 1'b0;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b1;
                        crc_d       = crc_next;
                        if (in_last_i) begin
                            crc_fin_d = crc_next ^ CRC_XOROUT;
                            idx_d     = '0;
                            state_d   = StCrc;
                        end
                    end else if (slot_free) begin
                        out_valid_d = 1'b0;
                    end
                end
                StCrc: begin
                    if (slot_free) begin
                        out_data_d  = crc_slice;
                        out_crc_d   = 1'b1;
                        out_valid_d = 1'b1;
                        out_last_d  = last_slice;
                        idx_d       = idx_q + IDX_W'(1);
                        if (last_slice) begin
                            // Re-arm for the next frame as soon as the last slice is loaded.
                            idx_d   = '0;
                            crc_d   = CRC_INIT;
                            state_d = StData;
                        end
                    end
                end
                default: begin
                    state_d = StData;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StData;
            crc_q       <= CRC_INIT;
            crc_fin_q   <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_crc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            crc_fin_q   <= crc_fin_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_crc_q   <= out_crc_d;
        end
    end

endmodule

// File: tb/tb_common_crc_framer.sv
// Directed bench for common_crc_framer with CRC-16/CCITT-FALSE defaults.
module tb_common_crc_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_crc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    common_crc_framer dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_crc_o   (out_crc)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Stream nframes copies of "123456789" and check every output handshake against
    // the expected payload + 0x29,0xB1 sequence; stalled beats must hold stable.
    task automatic run_frames(input string tag, input int nframes, input bit stall);
        int         pi = 0;
        int         oi = 0;
        int         cyc = 0;
        int         last_fire = -1;
        int         k;
        bit         held = 1'b0;
        bit         acc;
        logic [7:0] hd;
        logic       hl;
        logic       hc;
        logic [7:0] ed;
        logic       el;
        logic       ec;
        while (oi < 11 * nframes && cyc < 400) begin
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pi < 9 * nframes) begin
                in_valid = 1'b1;
                in_data  = 8'(8'h31 + pi % 9);
                in_last  = (pi % 9 == 8);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
                in_last  = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (held) begin
                chk1({tag, "_hold_valid"}, out_valid, 1'b1);
                chk8({tag, "_hold_data"}, out_data, hd);
                chk1({tag, "_hold_last"}, out_last, hl);
                chk1({tag, "_hold_crc"}, out_crc, hc);
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                k = oi % 11;
                if (k < 9) begin
                    ed = 8'(8'h31 + k); ec = 1'b0; el = 1'b0;
                end else if (k == 9) begin
                    ed = 8'h29; ec = 1'b1; el = 1'b0;
                end else begin
                    ed = 8'hB1; ec = 1'b1; el = 1'b1;
                end
                chk8({tag, "_data"}, out_data, ed);
                chk1({tag, "_crc"}, out_crc, ec);
                chk1({tag, "_last"}, out_last, el);
                oi++;
                last_fire = cyc;
            end else if (out_valid) begin
                held = 1'b1;
                hd   = out_data;
                hl   = out_last;
                hc   = out_crc;
            end
            if (acc) pi++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        chk32({tag, "_beats_out"}, oi, 11 * nframes);
        if (!stall) chk32({tag, "_last_fire_cycle"}, last_fire, 11 * nframes);
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk1("rst_valid", out_valid, 1'b0);
        chk8("rst_data", out_data, 8'h00);
        chk1("rst_last", out_last, 1'b0);
        chk1("rst_crc", out_crc, 1'b0);
        reset = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);

        // 1: "123456789" with 1-cycle latency, then 0x29, 0xB1.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + i);
            in_last  = (i == 8);
            #1;
            chk1("t1_in_ready", in_ready, 1'b1);
            tick();
            chk1("t1_valid", out_valid, 1'b1);
            chk8("t1_data", out_data, 8'(8'h31 + i));
            chk1("t1_crc", out_crc, 1'b0);
            chk1("t1_last", out_last, 1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk1("t1_ready_lo0", in_ready, 1'b0);
        tick();
        chk8("t1_crc0_data", out_data, 8'h29);
        chk1("t1_crc0_crc", out_crc, 1'b1);
        chk1("t1_crc0_last", out_last, 1'b0);
        chk1("t1_ready_lo1", in_ready, 1'b0);
        tick();
        chk8("t1_crc1_data", out_data, 8'hB1);
        chk1("t1_crc1_crc", out_crc, 1'b1);
        chk1("t1_crc1_last", out_last, 1'b1);
        chk1("t1_ready_hi", in_ready, 1'b1);
        tick();
        chk1("t1_idle_valid", out_valid, 1'b0);

        // 2: single beat 0x00 -> CRC 0xE1F0; in_ready low exactly 2 cycles.
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk8("t2_data", out_data, 8'h00);
        chk1("t2_crc_flag", out_crc, 1'b0);
        chk1("t2_ready_lo0", in_ready, 1'b0);
        tick();
        chk8("t2_crc0", out_data, 8'hE1);
        chk1("t2_crc0_last", out_last, 1'b0);
        chk1("t2_ready_lo1", in_ready, 1'b0);
        tick();
        chk8("t2_crc1", out_data, 8'hF0);
        chk1("t2_crc1_last", out_last, 1'b1);
        chk1("t2_ready_hi", in_ready, 1'b1);
        tick();

        // 3: random output stalls.
        run_frames("t3", 1, 1'b1);

        // 4: two back-to-back frames, no gap.
        run_frames("t4", 2, 1'b0);

        // 5: clear after 4 payload beats, then a full frame.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + i);
            in_last  = 1'b0;
            tick();
        end
        clear   = 1'b1;
        in_data = 8'h35;
        #1;
        chk1("t5_clear_ready", in_ready, 1'b0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk1("t5_clear_valid", out_valid, 1'b0);
        tick();
        chk1("t5_no_accept", out_valid, 1'b0);
        run_frames("t5", 1, 1'b0);

        // 6: reset while the first CRC slice is stalled.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + i);
            in_last  = (i == 8);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk8("t6_crc0", out_data, 8'h29);
        out_ready = 1'b0;
        tick();
        chk8("t6_stall_data", out_data, 8'h29);
        chk1("t6_stall_crc", out_crc, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk1("t6_rst_valid", out_valid, 1'b0);
        chk8("t6_rst_data", out_data, 8'h00);
        chk1("t6_rst_crc", out_crc, 1'b0);
        chk1("t6_rst_last", out_last, 1'b0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk1("t6_ready_after_rst", in_ready, 1'b1);
        run_frames("t6", 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
